// File: rtl/countdown_timer_pkg.sv
// Shared types for the countdown timer: run-state enum and the operation
// code the top level issues to the counter core each cycle.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ct_state_t;

    typedef enum logic [1:0] {
        CORE_HOLD  = 2'd0,
        CORE_CLEAR = 2'd1,
        CORE_LOAD  = 2'd2,
        CORE_DEC   = 2'd3
    } core_op_t;

endpackage

// File: rtl/down_counter_core.sv
// N-bit count register with clear / load / decrement, plus zero and one
// detection used by the controlling FSM.
module down_counter_core
    import countdown_timer_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         nrst,
    input  core_op_t     op,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] count,
    output logic         at_zero,
    output logic         at_one
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] count_reg;
    logic [N-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        unique case (op)
            CORE_CLEAR: count_next = '0;
            CORE_LOAD:  count_next = load_val;
            // Saturate at zero so a stray decrement can never wrap around.
            CORE_DEC:   count_next = (count_reg != '0) ? (count_reg - ONE) : count_reg;
            default:    count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count   = count_reg;
    assign at_zero = (count_reg == '0);
    assign at_one  = (count_reg == ONE);

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with optional auto-reload: counts enabled cycles
// down to zero, pulses expired once, then holds at zero or reloads.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         enable,
    input  logic         clear,
    input  logic         load,
    input  logic         reload,
    input  logic [N-1:0] start_val,
    output logic [N-1:0] count,
    output logic         at_zero,
    output logic         expired,
    output logic         busy
);

    ct_state_t    state_reg;
    ct_state_t    state_next;
    logic [N-1:0] reload_val_reg;
    logic [N-1:0] reload_val_next;
    logic         expired_reg;
    logic         expired_next;

    core_op_t     core_op;
    logic [N-1:0] core_load_val;
    logic         core_at_one;

    down_counter_core #(
        .N (N)
    ) u_core (
        .clk      (clk),
        .nrst     (nrst),
        .op       (core_op),
        .load_val (core_load_val),
        .count    (count),
        .at_zero  (at_zero),
        .at_one   (core_at_one)
    );

    // Priority: clear > load > run-time decrement/reload > hold.
    always_comb begin
        state_next      = state_reg;
        reload_val_next = reload_val_reg;
        expired_next    = 1'b0;
        core_op         = CORE_HOLD;
        core_load_val   = start_val;

        if (clear) begin
            core_op    = CORE_CLEAR;
            state_next = IDLE;
        end else if (load) begin
            core_op         = CORE_LOAD;
            core_load_val   = start_val;
            reload_val_next = start_val;
            state_next      = (start_val != '0) ? RUN : IDLE;
        end else begin
            unique case (state_reg)
                RUN: begin
                    if (enable) begin
                        if (at_zero) begin
                            // Only reachable in reload mode: zero cycle of the period.
                            core_op       = CORE_LOAD;
                            core_load_val = reload_val_reg;
                        end else if (core_at_one) begin
                            core_op      = CORE_DEC;
                            expired_next = 1'b1;
                            state_next   = reload ? RUN : DONE;
                        end else begin
                            core_op = CORE_DEC;
                        end
                    end
                end
                default: begin
                    core_op = CORE_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_reg      <= IDLE;
            reload_val_reg <= '0;
            expired_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            reload_val_reg <= reload_val_next;
            expired_reg    <= expired_next;
        end
    end

    assign expired = expired_reg;
    assign busy    = (state_reg == RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer (N=4): reset, one-shot, auto-reload,
// enable gating, control priority and zero-load corner cases.
module tb_countdown_timer;

    logic       tb_clk;
    logic       nrst;
    logic       enable;
    logic       clear;
    logic       load;
    logic       reload;
    logic [3:0] start_val;
    logic [3:0] count;
    logic       at_zero;
    logic       expired;
    logic       busy;

    int checks_cnt;
    int fail_cnt;

    countdown_timer #(
        .N (4)
    ) dut (
        .clk       (tb_clk),
        .nrst      (nrst),
        .enable    (enable),
        .clear     (clear),
        .load      (load),
        .reload    (reload),
        .start_val (start_val),
        .count     (count),
        .at_zero   (at_zero),
        .expired   (expired),
        .busy      (busy)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic check_val(input string tag, input int got, input int want);
        checks_cnt++;
        if (got != want) begin
            fail_cnt++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end else begin
            $display("ok   %s got=%0d", tag, got);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input int c, input int e, input int b);
        check_val({tag, ".count"},   int'(count),   c);
        check_val({tag, ".expired"}, int'(expired), e);
        check_val({tag, ".busy"},    int'(busy),    b);
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        nrst = 1'b0; enable = 1'b0; clear = 1'b0; load = 1'b0;
        reload = 1'b0; start_val = 4'd0;

        // Reset
        tick(); tick();
        check_outs("reset", 0, 0, 0);
        check_val("reset.at_zero", int'(at_zero), 1);
        nrst = 1'b1;

        // One-shot: load 5
        start_val = 4'd5; load = 1'b1; enable = 1'b1; reload = 1'b0;
        tick();
        load = 1'b0;
        check_outs("os_load", 5, 0, 1);
        for (int i = 4; i >= 0; i--) begin
            tick();
            check_outs($sformatf("os_c%0d", i), i, (i == 0) ? 1 : 0, (i == 0) ? 0 : 1);
        end
        check_val("os_at_zero", int'(at_zero), 1);
        // reload raised while DONE must not restart
        reload = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_outs($sformatf("os_hold%0d", i), 0, 0, 0);
        end

        // Auto-reload: load 15, period 16
        start_val = 4'd15; load = 1'b1; reload = 1'b1; enable = 1'b1;
        tick();
        load = 1'b0;
        check_outs("ar_load", 15, 0, 1);
        for (int k = 1; k <= 33; k++) begin
            tick();
            check_outs($sformatf("ar_k%0d", k), 15 - (k % 16), (k % 16 == 15) ? 1 : 0, 1);
        end

        // Enable gating: load 3
        reload = 1'b0; enable = 1'b0; start_val = 4'd3; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_outs($sformatf("eg_hold%0d", i), 3, 0, 1);
        end
        enable = 1'b1;
        tick(); check_outs("eg_c2", 2, 0, 1);
        enable = 1'b0;
        tick(); check_outs("eg_gap", 2, 0, 1);
        enable = 1'b1;
        tick(); check_outs("eg_c1", 1, 0, 1);
        tick(); check_outs("eg_c0", 0, 1, 0);
        tick(); check_outs("eg_after", 0, 0, 0);

        // clear + load together mid-run
        start_val = 4'd10; load = 1'b1; enable = 1'b1;
        tick();
        load = 1'b0;
        tick(); check_outs("cl_run", 9, 0, 1);
        clear = 1'b1; load = 1'b1; start_val = 4'd9;
        tick();
        clear = 1'b0; load = 1'b0;
        check_outs("cl_prio", 0, 0, 0);
        tick(); check_outs("cl_idle", 0, 0, 0);

        // nrst low together with load
        start_val = 4'd6; load = 1'b1;
        tick();
        load = 1'b0;
        tick(); check_outs("rs_run", 5, 0, 1);
        nrst = 1'b0; load = 1'b1; start_val = 4'd12;
        tick();
        nrst = 1'b1; load = 1'b0;
        check_outs("rs_prio", 0, 0, 0);
        check_val("rs_prio.at_zero", int'(at_zero), 1);

        // load 7 in the 1->0 cycle
        start_val = 4'd2; load = 1'b1;
        tick();
        load = 1'b0;
        tick(); check_outs("ld10_c1", 1, 0, 1);
        start_val = 4'd7; load = 1'b1;
        tick();
        load = 1'b0;
        check_outs("ld10_load", 7, 0, 1);
        tick(); check_outs("ld10_next", 6, 0, 1);

        // clear in the 1->0 cycle
        start_val = 4'd1; load = 1'b1;
        tick();
        load = 1'b0;
        check_outs("cl10_c1", 1, 0, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_outs("cl10_clr", 0, 0, 0);

        // load 1 one-shot: expires on the very next enabled edge
        start_val = 4'd1; load = 1'b1;
        tick();
        load = 1'b0;
        tick(); check_outs("one_c0", 0, 1, 0);

        // Zero load with enable high
        start_val = 4'd0; load = 1'b1; enable = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_outs($sformatf("zl%0d", i), 0, 0, 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable, parameterised down-counter with optional auto-reload. It is the counting-down counterpart of the team's up-counter (`enable` / `clear` / `wrap` / `max` / `count` / `at_max`). It sits beside that counter in timing and control paths that need "wait N enabled cycles, then signal". It raises a one-cycle `expired` pulse when the count reaches zero, then either holds at zero or reloads the start value.

## Interface
Parameters:
- `N`, 4, counter width in bits (N ≥ 2)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `nrst`  in  1  reset, synchronous, active-low; sampled on `clk` rising edge
- `enable`  in  1  count-down qualifier; no decrement when low
- `clear`  in  1  synchronous clear; highest priority after `nrst`
- `load`  in  1  capture `start_val` into count and reload register, start run
- `reload`  in  1  auto-reload on expiry (the down-counter analogue of `wrap`)
- `start_val`  in  N  value loaded on `load`
- `count`  out  N  current count
- `at_zero`  out  1  combinational, `count == 0`
- `expired`  out  1  registered one-cycle pulse, high in the first cycle `count` is 0 after a 1→0 decrement
- `busy`  out  1  high while state is RUN

## Operation
- State machine (shared enum): IDLE, RUN, DONE.
- Internal `reload_val` (N bits) holds the last loaded `start_val`.
- Per-edge priority: `nrst` low > `clear` > `load` > decrement/reload > hold.
- Reset:
  - `count`=0, `reload_val`=0, state IDLE, `expired`=0.
  - Therefore `at_zero`=1 and `busy`=0.
- `clear`:
  - `count`=0, state IDLE, `expired`=0.
  - `reload_val` is retained.
- `load`:
  - `count`=`start_val`, `reload_val`=`start_val`.
  - State becomes RUN if `start_val`≠0, else IDLE; no `expired` pulse.
  - A load in any state, including mid-run, restarts the run.
  - `enable` is ignored in the load cycle.
- RUN with `enable`=1:
  - `count`>1: decrement by 1.
  - `count`==1: `count`=0, `expired`=1 next cycle. Next state is RUN if `reload`=1, else DONE. `reload` is sampled in this cycle only.
  - `count`==0 (reload mode only): `count`=`reload_val`, stays RUN, no pulse.
- RUN with `enable`=0: hold. `expired` clears after its single cycle regardless of `enable`.
- DONE: `count` holds 0 and `busy`=0. Only `load`, `clear`, or reset leave DONE.
- IDLE: `count` holds; `enable` has no effect.
- Arithmetic: unsigned N-bit values. `count` never underflows; 0 is reached only from 1, by `clear`, by reset, or by loading 0.

## Timing
- Every output except `at_zero` is registered; `at_zero` follows `count` combinationally.
- `load` → new `count` and `busy` are visible 1 cycle later, after the capturing edge.
- Loading value V with `enable` held high: `count` reaches 0 exactly V edges after the load edge, and `expired` is high in that same cycle.
- Reload mode, V loaded, `enable` held high: period of V+1 cycles (V…1, 0, V…). One `expired` pulse per period.
- `clear` or reset in the cycle `count` goes 1→0 wins: no `expired` pulse.
- `load` in the 1→0 cycle wins: `count`=`start_val`, no pulse.

## Structure
- Package `countdown_timer_pkg`: `typedef enum logic [1:0] {IDLE, RUN, DONE} ct_state_t`.
- Optional sub-module `down_counter_core`:
  - Contains the N-bit register with clear/load/decrement, plus `at_zero`.
  - The top level holds the FSM, `reload_val`, and the `expired` register.

## Test plan
- Reset: `nrst` low for 2 cycles → `count`=0, `at_zero`=1, `busy`=0, `expired`=0.
- One-shot: load 5, `reload`=0, `enable`=1 → `count` 5,4,3,2,1,0. `expired` is high only in the first 0 cycle. `busy`=0 afterwards, and `count` stays 0 after 10 more cycles.
- Auto-reload (N=4): load 15, `reload`=1, `enable`=1 → `count` 15…1,0,15. `expired` pulses every 16 cycles, `busy` stays 1.
- Enable gating: load 3, `enable`=0 for 4 cycles → `count` stays 3. Raise `enable` → 2,1,0 with one pulse.
- Priority:
  - `clear` and `load`=9 together mid-run → `count`=0, IDLE, no pulse.
  - `nrst` low together with `load` → reset values.
  - `load` 7 during the 1→0 cycle → `count`=7, no pulse.
- Zero load: load 0 with `enable`=1 → `count`=0, `busy`=0, `expired` never asserted.
